// File: rtl/fb_pkg.sv
// ============================================================================
// Module      : fb_pkg
// Description : Shared types, sizes and address helper for the frame buffer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fb_pkg;

    localparam int H_PIX     = 160;
    localparam int V_PIX     = 120;
    localparam int FB_DEPTH  = 19200;
    localparam int FB_ADDR_W = 15;
    localparam int PIX_W     = 12;

    typedef logic [11:0] pixel_t;
    typedef logic [14:0] fb_addr_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_t;

    localparam fb_addr_t FB_LAST_ADDR = fb_addr_t'(FB_DEPTH - 1);

    // y*160 + x built from shifts so no multiplier is needed.
    function automatic fb_addr_t fb_xy_to_addr(input logic [7:0] x, input logic [6:0] y);
        fb_addr_t y15;
        fb_addr_t x15;
        y15 = fb_addr_t'(y);
        x15 = fb_addr_t'(x);
        return (y15 << 7) + (y15 << 5) + x15;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fb_clear_engine.sv
// ============================================================================
// Module      : fb_clear_engine
// Description : Full-screen clear sequencer: address counter, latched fill
//               colour and busy/done flags.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_clear_engine
    import fb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [PIX_W-1:0] color_i,
    input  logic             wr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [14:0]      addr_o,
    output logic [PIX_W-1:0] color_o,
    output logic             last_o
);

    fb_addr_t cnt_q,   cnt_d;
    pixel_t   color_q, color_d;
    logic     busy_q,  busy_d;
    logic     done_q,  done_d;

    assign last_o  = busy_q && wr_i && (cnt_q == FB_LAST_ADDR);
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign addr_o  = cnt_q;
    assign color_o = color_q;

    always_comb begin
        cnt_d   = cnt_q;
        color_d = color_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start_i && !busy_q) begin
            cnt_d   = '0;
            color_d = color_i;
            busy_d  = 1'b1;
        end else if (busy_q && wr_i) begin
            if (cnt_q == FB_LAST_ADDR) begin
                cnt_d  = '0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 15'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            color_q <= color_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fb_access_ctrl.sv
// ============================================================================
// Module      : fb_access_ctrl
// Description : Single-port frame buffer arbiter: display read > clear write
//               > draw write. Clear engine built only when FB_CLEAR_EN is set.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_access_ctrl #(
    parameter int H_PIX = 160,
    parameter int V_PIX = 120,
    parameter int PIX_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             disp_req,
    input  logic [14:0]      disp_addr,
    output logic             disp_valid,
    output logic [PIX_W-1:0] disp_data,
    input  logic             draw_req,
    input  logic [7:0]       draw_x,
    input  logic [6:0]       draw_y,
    input  logic [PIX_W-1:0] draw_color,
    output logic             draw_ack,
    input  logic             clr_start,
    input  logic [PIX_W-1:0] clr_color,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             ram_we,
    output logic [14:0]      ram_a,
    output logic [PIX_W-1:0] ram_wd,
    input  logic [PIX_W-1:0] ram_rd
);

    import fb_pkg::*;

    localparam logic [7:0] X_LIM = 8'(H_PIX);
    localparam logic [6:0] Y_LIM = 7'(V_PIX);

    fb_state_t        state_q, state_d;
    logic             ram_we_q, ram_we_d;
    logic [14:0]      ram_a_q,  ram_a_d;
    logic [PIX_W-1:0] ram_wd_q, ram_wd_d;
    logic             rd_p1_q;
    logic             disp_valid_q;

    logic             w_clr_req;
    logic             w_clr_go;
    logic             w_clr_wr;
    logic             w_clr_last;
    logic [14:0]      w_clr_addr;
    logic [PIX_W-1:0] w_clr_color;
    logic             w_clr_busy;
    logic             w_clr_done;

    logic [14:0]      w_draw_addr;
    logic             w_draw_in;

    assign w_draw_addr = fb_xy_to_addr(draw_x, draw_y);
    assign w_draw_in   = (draw_x < X_LIM) && (draw_y < Y_LIM);

`ifdef FB_CLEAR_EN
    assign w_clr_req = clr_start;

    fb_clear_engine u_clear (
        .clk     (clk),
        .reset   (reset),
        .start_i (w_clr_go),
        .color_i (clr_color),
        .wr_i    (w_clr_wr),
        .busy_o  (w_clr_busy),
        .done_o  (w_clr_done),
        .addr_o  (w_clr_addr),
        .color_o (w_clr_color),
        .last_o  (w_clr_last)
    );
`else
    logic unused_clr;

    assign w_clr_req   = 1'b0;
    assign w_clr_busy  = 1'b0;
    assign w_clr_done  = 1'b0;
    assign w_clr_addr  = '0;
    assign w_clr_color = '0;
    assign w_clr_last  = 1'b0;
    assign unused_clr  = ^{clr_start, clr_color, w_clr_go, w_clr_wr};
`endif

    always_comb begin
        state_d  = state_q;
        ram_we_d = 1'b0;
        ram_a_d  = ram_a_q;
        ram_wd_d = ram_wd_q;
        draw_ack = 1'b0;
        w_clr_go = 1'b0;
        w_clr_wr = 1'b0;
        if (disp_req) begin
            ram_a_d = disp_addr;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_clr_req) begin
                        w_clr_go = 1'b1;
                        state_d  = ST_CLEAR;
                    end else if (draw_req) begin
                        // Out-of-range pixels are acknowledged but never written.
                        draw_ack = 1'b1;
                        if (w_draw_in) begin
                            ram_we_d = 1'b1;
                            ram_a_d  = w_draw_addr;
                            ram_wd_d = draw_color;
                        end
                    end
                end
                ST_CLEAR: begin
                    w_clr_wr = 1'b1;
                    ram_we_d = 1'b1;
                    ram_a_d  = w_clr_addr;
                    ram_wd_d = w_clr_color;
                    if (w_clr_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ram_we_q     <= 1'b0;
            ram_a_q      <= '0;
            ram_wd_q     <= '0;
            rd_p1_q      <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_we_q     <= ram_we_d;
            ram_a_q      <= ram_a_d;
            ram_wd_q     <= ram_wd_d;
            rd_p1_q      <= disp_req;
            disp_valid_q <= rd_p1_q;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_a      = ram_a_q;
    assign ram_wd     = ram_wd_q;
    assign disp_valid = disp_valid_q;
    // RAM output is already registered, so read data is forwarded directly.
    assign disp_data  = disp_valid_q ? ram_rd : '0;
    assign clr_busy   = w_clr_busy;
    assign clr_done   = w_clr_done;

endmodule

`default_nettype wire
